// File: rtl/crossbar_rr_if.sv
// Handshake bundle for the registered round-robin crossbar.
// The slave modport is the switch; the master modport is the surrounding producer/consumer side.
interface crossbar_rr_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 8
);
   localparam int unsigned DSTW = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned SRCW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]      in_valid;
   logic [N*DSTW-1:0] in_dest;
   logic [N*DW-1:0]   in_data;
   logic [N-1:0]      in_ready;
   logic [M-1:0]      out_valid;
   logic [M*DW-1:0]   out_data;
   logic [M*SRCW-1:0] out_src;
   logic [M-1:0]      out_ready;

   modport master (
      output in_valid, in_dest, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  in_valid, in_dest, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/crossbar_rr.sv
// N-input by M-output registered crossbar with an independent round-robin arbiter per output.
// in_ready is combinational from the request side and out_ready; each output holds one beat.
module crossbar_rr #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 8,
   parameter int unsigned M  = 8
) (
   input  logic         clk,
   input  logic         rst,
   crossbar_rr_if.slave bus
);
   localparam int unsigned DSTW = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned SRCW = (N > 1) ? $clog2(N) : 1;

   logic [SRCW-1:0]         ptr_q [M];
   logic [M-1:0][N-1:0]     req;
   logic [M-1:0][N-1:0]     gnt;
   logic [M-1:0]            load_ok;
   logic [M-1:0]            gfound;
   logic [SRCW-1:0]         gidx  [M];
   logic [SRCW-1:0]         gnext [M];
   logic [DW-1:0]           gdata [M];
   logic [N-1:0]            dest_bad;
   logic [N-1:0]            gnt_any;

   // Per-output request matrix; out-of-range destinations are flagged separately.
   always_comb begin
      dest_bad = '0;
      req      = '0;
      for (int i = 0; i < N; i++) begin
         dest_bad[i] = 32'(bus.in_dest[i*DSTW +: DSTW]) >= M;
         for (int o = 0; o < M; o++) begin
            req[o][i] = bus.in_valid[i] && !rst &&
                        (bus.in_dest[i*DSTW +: DSTW] == DSTW'(o));
         end
      end
   end

   // Round-robin pick: first requester at or above ptr, else wrap to the lowest requester.
   always_comb begin
      gnt     = '0;
      gfound  = '0;
      load_ok = '0;
      for (int o = 0; o < M; o++) begin
         gidx[o]    = '0;
         gnext[o]   = '0;
         gdata[o]   = '0;
         load_ok[o] = !bus.out_valid[o] || bus.out_ready[o];
         for (int i = 0; i < N; i++) begin
            if (!gfound[o] && load_ok[o] && req[o][i] && (SRCW'(i) >= ptr_q[o])) begin
               gfound[o] = 1'b1;
               gnt[o][i] = 1'b1;
               gidx[o]   = SRCW'(i);
               gnext[o]  = SRCW'((i + 1) % N);
               gdata[o]  = bus.in_data[i*DW +: DW];
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!gfound[o] && load_ok[o] && req[o][i]) begin
               gfound[o] = 1'b1;
               gnt[o][i] = 1'b1;
               gidx[o]   = SRCW'(i);
               gnext[o]  = SRCW'((i + 1) % N);
               gdata[o]  = bus.in_data[i*DW +: DW];
            end
         end
      end
   end

   // An input is accepted when granted, or dropped outright when its destination does not exist.
   always_comb begin
      gnt_any = '0;
      for (int o = 0; o < M; o++) begin
         gnt_any = gnt_any | gnt[o];
      end
      bus.in_ready = bus.in_valid & {N{!rst}} & (dest_bad | gnt_any);
   end

   // Output holding registers and arbitration pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= '0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
         for (int o = 0; o < M; o++) begin
            ptr_q[o] <= '0;
         end
      end else begin
         for (int o = 0; o < M; o++) begin
            if (load_ok[o]) begin
               bus.out_valid[o] <= gfound[o];
               if (gfound[o]) begin
                  bus.out_data[o*DW +: DW]     <= gdata[o];
                  bus.out_src[o*SRCW +: SRCW]  <= gidx[o];
                  ptr_q[o]                     <= gnext[o];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_crossbar_rr.sv
// Bench for crossbar_rr: table-driven handshake vectors with a per-output scoreboard,
// plus hand sequences for backpressure, mid-run reset and invalid destinations (M=6 instance).
module tb_crossbar_rr;
   localparam int unsigned DW   = 16;
   localparam int unsigned N    = 8;
   localparam int unsigned M    = 8;
   localparam int unsigned M6   = 6;
   localparam int unsigned DSTW = 3;
   localparam int unsigned SRCW = 3;

   typedef struct packed {
      logic [N-1:0]      vld;
      logic [N*DSTW-1:0] dst;
      logic [N*DW-1:0]   dat;
      logic [M-1:0]      ord;
      logic [N-1:0]      rdy;
      logic [M-1:0]      ov;
   } row_t;

   typedef struct {
      int              o;
      logic [DW-1:0]   d;
      logic [SRCW-1:0] s;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst;
   int    total = 0;
   int    bad   = 0;
   beat_t sbq [$];
   row_t  rows [$];

   always #5 clk = ~clk;

   crossbar_rr_if #(.DW(DW), .N(N), .M(M))  bus  ();
   crossbar_rr_if #(.DW(DW), .N(N), .M(M6)) bus6 ();

   crossbar_rr #(.DW(DW), .N(N), .M(M))  dut  (.clk(clk), .rst(rst), .bus(bus));
   crossbar_rr #(.DW(DW), .N(N), .M(M6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clr_in();
      bus.in_valid = '0;
      bus.in_dest  = '0;
      bus.in_data  = '0;
   endtask

   task automatic set_in(input int i, input logic [DSTW-1:0] d, input logic [DW-1:0] data);
      bus.in_valid[i]             = 1'b1;
      bus.in_dest[i*DSTW +: DSTW] = d;
      bus.in_data[i*DW +: DW]     = data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop beats that drain this cycle, then record beats accepted this cycle.
   task automatic sb_step();
      int    hit;
      int    d;
      beat_t b;
      for (int o = 0; o < M; o++) begin
         if (bus.out_valid[o] && bus.out_ready[o]) begin
            hit = -1;
            foreach (sbq[j]) if (hit < 0 && sbq[j].o == o) hit = j;
            if (hit < 0) begin
               total++;
               bad++;
               $display("FAIL sb_out%0d_unexpected: got beat %0h want none", o,
                        bus.out_data[o*DW +: DW]);
            end else begin
               chk($sformatf("sb_out%0d_data", o), 128'(bus.out_data[o*DW +: DW]), 128'(sbq[hit].d));
               chk($sformatf("sb_out%0d_src", o), 128'(bus.out_src[o*SRCW +: SRCW]), 128'(sbq[hit].s));
               sbq.delete(hit);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (bus.in_valid[i] && bus.in_ready[i]) begin
            d = int'(bus.in_dest[i*DSTW +: DSTW]);
            if (d < int'(M)) begin
               b.o = d;
               b.d = bus.in_data[i*DW +: DW];
               b.s = SRCW'(i);
               sbq.push_back(b);
            end
         end
      end
   endtask

   initial begin
      row_t r;

      // Single transfer, idle, 6 cycles of 3-way contention, idle, permutation, two idles.
      r = '0; r.vld[3] = 1'b1; r.dst[3*DSTW +: DSTW] = 3'd5; r.dat[3*DW +: DW] = 16'hA5A5;
      r.ord = '1; r.rdy = 8'h08; r.ov = 8'h00; rows.push_back(r);
      r = '0; r.ord = '1; r.ov = 8'h20; rows.push_back(r);
      for (int c = 0; c < 6; c++) begin
         r = '0;
         foreach (r.vld[i]) begin
            if (i == 0 || i == 2 || i == 7) begin
               r.vld[i] = 1'b1;
               r.dst[i*DSTW +: DSTW] = 3'd1;
               r.dat[i*DW +: DW] = DW'(i);
            end
         end
         r.ord = '1;
         r.rdy = (c % 3 == 0) ? 8'h01 : (c % 3 == 1) ? 8'h04 : 8'h80;
         r.ov  = (c == 0) ? 8'h00 : 8'h02;
         rows.push_back(r);
      end
      r = '0; r.ord = '1; r.ov = 8'h02; rows.push_back(r);
      r = '0;
      for (int i = 0; i < N; i++) begin
         r.vld[i] = 1'b1;
         r.dst[i*DSTW +: DSTW] = DSTW'(7 - i);
         r.dat[i*DW +: DW] = DW'(16'h100 + i);
      end
      r.ord = '1; r.rdy = 8'hFF; r.ov = 8'h00; rows.push_back(r);
      r = '0; r.ord = '1; r.ov = 8'hFF; rows.push_back(r);
      r = '0; r.ord = '1; r.ov = 8'h00; rows.push_back(r);

      // Reset, with a request present during the reset cycle.
      rst = 1'b1;
      clr_in();
      bus.out_ready   = '1;
      bus6.in_valid   = '0;
      bus6.in_dest    = '0;
      bus6.in_data    = '0;
      bus6.out_ready  = '1;
      tick();
      set_in(0, 3'd0, 16'h1234);
      #1;
      chk("reset_in_ready", 128'(bus.in_ready), 128'(0));
      chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
      chk("reset_out_data", bus.out_data, 128'(0));
      chk("reset_out_src", 128'(bus.out_src), 128'(0));
      tick();
      rst = 1'b0;
      clr_in();

      foreach (rows[j]) begin
         bus.in_valid  = rows[j].vld;
         bus.in_dest   = rows[j].dst;
         bus.in_data   = rows[j].dat;
         bus.out_ready = rows[j].ord;
         #1;
         chk($sformatf("row%0d_in_ready", j), 128'(bus.in_ready), 128'(rows[j].rdy));
         chk($sformatf("row%0d_out_valid", j), 128'(bus.out_valid), 128'(rows[j].ov));
         sb_step();
         tick();
      end

      // Backpressure: out 4 held while input 6 waits, then drain and refill in one cycle.
      clr_in(); set_in(0, 3'd4, 16'h4444); bus.out_ready = '1; #1;
      chk("bp_load_in_ready", 128'(bus.in_ready), 128'(8'h01));
      sb_step(); tick();
      for (int c = 0; c < 5; c++) begin
         clr_in(); set_in(6, 3'd4, 16'h6666); bus.out_ready = 8'hEF; #1;
         chk($sformatf("bp_hold%0d_in_ready", c), 128'(bus.in_ready), 128'(0));
         chk($sformatf("bp_hold%0d_out_valid", c), 128'(bus.out_valid), 128'(8'h10));
         chk($sformatf("bp_hold%0d_data", c), 128'(bus.out_data[4*DW +: DW]), 128'(16'h4444));
         chk($sformatf("bp_hold%0d_src", c), 128'(bus.out_src[4*SRCW +: SRCW]), 128'(0));
         sb_step(); tick();
      end
      bus.out_ready = '1; #1;
      chk("bp_release_in_ready", 128'(bus.in_ready), 128'(8'h40));
      sb_step(); tick();
      clr_in(); #1;
      chk("bp_new_out_valid", 128'(bus.out_valid), 128'(8'h10));
      chk("bp_new_data", 128'(bus.out_data[4*DW +: DW]), 128'(16'h6666));
      chk("bp_new_src", 128'(bus.out_src[4*SRCW +: SRCW]), 128'(6));
      sb_step(); tick();
      #1;
      chk("bp_idle_out_valid", 128'(bus.out_valid), 128'(0));

      // Reset mid-operation: outputs 2/3 full, pointers advanced, then reset.
      clr_in(); bus.out_ready = '0;
      set_in(0, 3'd2, 16'h2222); set_in(1, 3'd3, 16'h3333); #1;
      chk("mr_fill_in_ready", 128'(bus.in_ready), 128'(8'h03));
      sb_step(); tick();
      clr_in(); set_in(0, 3'd2, 16'hA000); set_in(5, 3'd2, 16'hA005);
      rst = 1'b1; #1;
      chk("mr_held_out_valid", 128'(bus.out_valid), 128'(8'h0C));
      chk("mr_rst_in_ready", 128'(bus.in_ready), 128'(0));
      tick();
      sbq.delete();
      rst = 1'b0; bus.out_ready = '1; #1;
      chk("mr_after_out_valid", 128'(bus.out_valid), 128'(0));
      chk("mr_after_out_data", bus.out_data, 128'(0));
      chk("mr_after_out_src", 128'(bus.out_src), 128'(0));
      chk("mr_first_grant", 128'(bus.in_ready), 128'(8'h01));
      sb_step(); tick();
      #1;
      chk("mr_second_grant", 128'(bus.in_ready), 128'(8'h20));
      chk("mr_second_out_valid", 128'(bus.out_valid), 128'(8'h04));
      sb_step(); tick();
      clr_in(); #1;
      chk("mr_last_out_valid", 128'(bus.out_valid), 128'(8'h04));
      sb_step(); tick();

      // Invalid destinations on the M=6 instance are consumed and dropped.
      bus6.in_valid = 8'h0E;
      bus6.in_dest[1*DSTW +: DSTW] = 3'd7;
      bus6.in_dest[2*DSTW +: DSTW] = 3'd4;
      bus6.in_dest[3*DSTW +: DSTW] = 3'd6;
      bus6.in_data[2*DW +: DW]     = 16'hBEEF;
      #1;
      chk("inv_in_ready", 128'(bus6.in_ready), 128'(8'h0E));
      chk("inv_pre_out_valid", 128'(bus6.out_valid), 128'(0));
      tick();
      bus6.in_valid = '0; #1;
      chk("inv_out_valid", 128'(bus6.out_valid), 128'(6'b010000));
      chk("inv_out_data", 128'(bus6.out_data[4*DW +: DW]), 128'(16'hBEEF));
      chk("inv_out_src", 128'(bus6.out_src[4*SRCW +: SRCW]), 128'(2));
      tick();

      chk("sb_drained", 128'(sbq.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/crossbar_rr.md
# crossbar_rr

Registered N-input by M-output crossbar switch with valid/ready handshakes on every port and an independent round-robin arbiter per output. Successor to the combinational one-hot-select crossbar: each input carries its own destination index, contention is resolved in hardware, and each output holds a one-entry register with backpressure. It sits between producers and consumers that need any-to-any routing with flow control.

## Interface
- DW, 16, data width per port
- N, 8, number of input ports (≥1)
- M, 8, number of output ports (≥1)
- DSTW, $clog2(M) floored at 1, destination index width (derived, do not override)
- SRCW, $clog2(N) floored at 1, source index width (derived, do not override)

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  N  per-input beat valid
- in_dest  input  N*DSTW  per-input destination index, concatenated (input i at [i*DSTW +: DSTW])
- in_data  input  N*DW  per-input data, concatenated
- in_ready  output  N  per-input accept; transfer when in_valid[i] & in_ready[i]
- out_valid  output  M  per-output register holds a beat
- out_data  output  M*DW  per-output data, concatenated
- out_src  output  M*SRCW  index of input that supplied the held beat
- out_ready  input  M  per-output consumer accept; drain when out_valid[o] & out_ready[o]

## Operation
- Per output o: request vector req_o[i] = in_valid[i] & (in_dest[i] == o).
- Output o can load when out_valid[o]==0 or out_ready[o]==1 (drain and refill same cycle).
- If loadable and req_o nonzero: grant one input by round-robin starting from ptr[o]; in_ready[granted]=1; next edge loads out_data[o]=in_data[i], out_src[o]=i, out_valid[o]=1, ptr[o]=(i+1) mod N.
- If loadable and req_o zero: out_valid[o] clears if it was draining; ptr[o] unchanged.
- If not loadable: no grant, ptr[o], out_data[o], out_src[o] hold.
- An input targets exactly one output per cycle, so at most one grant per input; in_ready[i]=0 for ungranted valid inputs.
- Invalid destination (in_dest[i] ≥ M, possible only when M not a power of two): in_ready[i]=1, beat consumed and discarded, no output affected.
- in_ready[i] when in_valid[i]==0: 0 (don't-care for verification, but RTL drives 0).
- Different outputs operate fully in parallel; no global stall.
- Data/src registers update only on load; out_data/out_src undefined-but-stable when out_valid=0 (bench checks them only with out_valid=1).

## Timing
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_src=0, all ptr=0; in_ready low during reset cycle regardless of inputs.
- Latency: beat accepted at edge k appears with out_valid at edge k, visible cycle k+1; one cycle input-to-output.
- Throughput: one beat per output per cycle under continuous out_ready=1.
- in_ready is combinational from in_valid, in_dest, out_valid, out_ready and ptr; out_ready→in_ready is a combinational path (documented; no skid buffer).
- Held beat: while out_valid[o]=1 and out_ready[o]=0, out_data[o]/out_src[o] must be stable.
- Fairness: with K inputs continuously requesting output o and out_ready=1, each is granted exactly once every K cycles.
- Reset mid-operation: held beats are discarded, pointers return to 0; no grant issued in the reset cycle.

## Test plan
- Single transfer: N=M=8, input 3 sends 0xA5A5 to dest 5, out_ready=1 -> in_ready[3]=1 same cycle; next cycle out_valid[5]=1, out_data[5]=0xA5A5, out_src[5]=3; all other out_valid=0.
- Contention: inputs 0,2,7 continuously send to dest 1 with data = input index -> out_src[1] sequence 0,2,7,0,2,7; each in_ready high one cycle in three.
- Backpressure: out_ready[4]=0 with out_valid[4]=1, input 6 requests dest 4 for 5 cycles -> in_ready[6]=0, out_data[4] stable; raise out_ready[4] -> input 6 granted that same cycle, new data next cycle.
- Parallel permutation: input i sends 0x100+i to dest (7-i) all in one cycle -> all in_ready=1; next cycle out_data[7-i]=0x100+i, out_src=i for all 8 outputs.
- Reset mid-operation: outputs 2 and 3 full with out_ready=0, assert rst one cycle -> out_valid=0, ptrs 0; after release, two inputs on one dest granted lowest-index first.
- Invalid dest: M=6, input 1 sends dest 7 -> in_ready[1]=1, no out_valid asserts next cycle.
